// File: rtl/dma_write_engine.sv
// DMA write engine: moves ceil(length/4) device blocks into memory as 4-word block writes,
// holding the memory bus between bus request (BR) and grant (BG).
module dma_write_engine #(
    parameter int WORD_SIZE    = 16,
    parameter int BLOCK_SIZE   = 64,
    parameter int WRITE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WORD_SIZE-1:0]  cmd_addr,
    input  logic [WORD_SIZE-1:0]  cmd_length,
    input  logic                  dev_valid,
    output logic                  dev_ready,
    input  logic [BLOCK_SIZE-1:0] dev_data,
    output logic                  BR,
    input  logic                  BG,
    output logic                  d_writeM,
    output logic [WORD_SIZE-1:0]  d_address,
    output logic [BLOCK_SIZE-1:0] d_data_out,
    output logic                  dma_end,
    output logic [2:0]            fsm_state
);
    localparam int CW = $clog2(WRITE_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] blocks;
    logic [CW-1:0]        wcnt;
    logic [WORD_SIZE:0]   len_round;
    logic [WORD_SIZE-1:0] new_blocks;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // cmd_ready is high only in IDLE, dev_ready only in FETCH while the bus is granted.
    assign dev_ready = (state == FETCH) && BG;
    assign fsm_state = state;

    // One extra bit so a length near 2^WORD_SIZE still rounds up correctly.
    assign len_round  = {1'b0, cmd_length} + (WORD_SIZE + 1)'(3);
    assign new_blocks = WORD_SIZE'(len_round >> 2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            BR         <= 1'b0;
            d_writeM   <= 1'b0;
            dma_end    <= 1'b0;
            d_address  <= '0;
            d_data_out <= '0;
            blocks     <= '0;
            wcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        d_address <= cmd_addr & ~WORD_SIZE'(3);
                        blocks    <= new_blocks;
                        cmd_ready <= 1'b0;
                        if (new_blocks == '0) begin
                            state   <= DONE;
                            dma_end <= 1'b1;
                        end else begin
                            state <= REQ;
                            BR    <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (BG) state <= FETCH;
                end
                FETCH: begin
                    if (!BG) begin
                        state <= REQ;
                    end else if (dev_valid) begin
                        d_data_out <= dev_data;
                        d_writeM   <= 1'b1;
                        wcnt       <= '0;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    // BG is deliberately ignored here: a started block always completes.
                    if (wcnt == CW'(WRITE_CYCLES - 1)) begin
                        d_writeM  <= 1'b0;
                        d_address <= d_address + WORD_SIZE'(4);
                        blocks    <= blocks - WORD_SIZE'(1);
                        if (blocks == WORD_SIZE'(1)) begin
                            state   <= DONE;
                            BR      <= 1'b0;
                            dma_end <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                DONE: begin
                    dma_end   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    BR        <= 1'b0;
                    d_writeM  <= 1'b0;
                    dma_end   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_write_engine.sv
// Bench for dma_write_engine: directed corner cases plus randomized transfers, checked
// against an address/data scoreboard derived from the command and device handshakes.
module tb_dma_write_engine;
    localparam int W  = 16;
    localparam int B  = 64;
    localparam int WC = 3;

    logic         clk;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_addr;
    logic [W-1:0] cmd_length;
    logic         dev_valid;
    logic         dev_ready;
    logic [B-1:0] dev_data;
    logic         BR;
    logic         BG;
    logic         d_writeM;
    logic [W-1:0] d_address;
    logic [B-1:0] d_data_out;
    logic         dma_end;
    logic [2:0]   fsm_state;

    dma_write_engine #(.WORD_SIZE(W), .BLOCK_SIZE(B), .WRITE_CYCLES(WC)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_length(cmd_length),
        .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_data(dev_data),
        .BR(BR), .BG(BG),
        .d_writeM(d_writeM), .d_address(d_address), .d_data_out(d_data_out),
        .dma_end(dma_end), .fsm_state(fsm_state)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected write addresses from the command, blocks as the device handed them over.
    logic [W-1:0] exp_q[$];
    logic [B-1:0] acc_q[$];

    int cyc = 0, run = 0, write_starts = 0, end_cnt = 0, br_cycles = 0;
    logic prev_end = 1'b0;
    logic [W-1:0] cur_addr;
    logic [B-1:0] cur_data;

    int bg_pct = 100, dev_pct = 100;
    logic bg_auto = 1'b1, bg_manual = 1'b0;
    int cur_nb, acc_cyc, ws_base, end_base, br_base;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus grant follows BR one cycle later (optionally with random drops); device data is random.
    always @(posedge clk) begin
        #2;
        if (bg_auto) BG = BR && ($urandom_range(0, 99) < bg_pct);
        else BG = bg_manual;
        dev_valid = ($urandom_range(0, 99) < dev_pct);
        dev_data = {$urandom, $urandom};
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            run = 0;
            prev_end = 1'b0;
        end else begin
            chk("ready_write_excl", {63'd0, dev_ready & d_writeM}, 64'd0);
            if (BR) br_cycles++;
            if (dma_end) begin
                end_cnt++;
                chk("end_single_cycle", {63'd0, prev_end}, 64'd0);
            end
            prev_end = dma_end;
            if (dev_valid && dev_ready) acc_q.push_back(dev_data);
            if (d_writeM) begin
                if (run == 0) begin
                    chk("write_expected", exp_q.size() > 0, 1);
                    chk("block_available", acc_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("write_addr", d_address, exp_q.pop_front());
                    if (acc_q.size() > 0) chk("write_data", d_data_out, acc_q.pop_front());
                    chk("br_during_write", BR, 1);
                    cur_addr = d_address;
                    cur_data = d_data_out;
                    write_starts++;
                end else begin
                    chk("addr_stable", d_address, cur_addr);
                    chk("data_stable", d_data_out, cur_data);
                end
                run++;
            end else if (run != 0) begin
                chk("write_length", run, WC);
                run = 0;
            end
        end
    end

    task automatic issue_cmd(input logic [W-1:0] addr, input logic [W-1:0] len);
        int guard = 0;
        logic [W-1:0] a;
        while (cmd_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cur_nb = (int'(len) + 3) / 4;
        a = addr & 16'hFFFC;
        for (int i = 0; i < cur_nb; i++) begin
            exp_q.push_back(a);
            a = a + 16'd4;
        end
        ws_base = write_starts; end_base = end_cnt; br_base = br_cycles;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_length = len;
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0; cmd_addr = 16'($urandom); cmd_length = 16'($urandom);
        chk("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic wait_done(input bit lat_check);
        int guard = 0;
        bit got = 0;
        while (!got && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
            if (dma_end) begin
                got = 1;
                cmd_valid = 1'b0;
            end else begin
                cmd_valid = ($urandom_range(0, 3) == 0);
            end
        end
        cmd_valid = 1'b0;
        chk("dma_end_seen", got, 1);
        if (lat_check) chk("latency", cyc - acc_cyc, (cur_nb == 0) ? 1 : 2 + cur_nb * (1 + WC));
        chk("write_count", write_starts - ws_base, cur_nb);
        chk("all_writes_done", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("br_low_after", BR, 0);
        chk("ready_after", cmd_ready, 1);
        chk("one_dma_end", end_cnt - end_base, 1);
    endtask

    initial begin
        int guard;
        int e0;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_length = '0;
        BG = 1'b0; dev_valid = 1'b0; dev_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_br", BR, 0);
        chk("rst_dev_ready", dev_ready, 0);
        chk("rst_writem", d_writeM, 0);
        chk("rst_dma_end", dma_end, 0);
        chk("rst_address", d_address, 0);
        chk("rst_data", d_data_out, 0);
        reset_n = 1'b1;

        // Three blocks at full rate.
        issue_cmd(16'h01F4, 16'd12);
        wait_done(1);

        // Zero length: immediate completion, bus never requested.
        issue_cmd(16'h0040, 16'd0);
        wait_done(1);
        chk("zero_len_no_br", br_cycles - br_base, 0);

        // Unaligned start, partial last block.
        issue_cmd(16'h0023, 16'd5);
        wait_done(1);

        // Address wrap.
        issue_cmd(16'hFFFC, 16'd8);
        wait_done(1);

        // Grant withdrawn during the second block's write.
        bg_auto = 1'b0; bg_manual = 1'b1;
        issue_cmd(16'h0100, 16'd12);
        guard = 0;
        while (write_starts - ws_base < 2 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("second_write_started", write_starts - ws_base, 2);
        @(posedge clk); #1;
        bg_manual = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("hold_br", BR, 1);
        chk("hold_no_write", d_writeM, 0);
        chk("hold_no_ready", dev_ready, 0);
        chk("hold_addr", d_address, 16'h0108);
        chk("hold_writes", write_starts - ws_base, 2);
        bg_manual = 1'b1;
        wait_done(0);
        bg_auto = 1'b1;

        // Reset during the first write cycle abandons the transfer.
        issue_cmd(16'h0200, 16'd8);
        guard = 0;
        while (write_starts - ws_base < 1 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("abort_write_started", write_starts - ws_base, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_writem", d_writeM, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_br", BR, 0);
        chk("abort_dma_end", dma_end, 0);
        chk("abort_address", d_address, 0);
        e0 = end_cnt;
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_end", end_cnt - e0, 0);
        reset_n = 1'b1;
        issue_cmd(16'h0300, 16'd8);
        wait_done(1);

        // Randomized transfers with random grant and device stalls.
        for (int t = 0; t < 12; t++) begin
            bit full;
            bg_pct  = (t % 3 == 0) ? 100 : $urandom_range(50, 100);
            dev_pct = (t % 3 == 0) ? 100 : $urandom_range(40, 100);
            full = (bg_pct == 100) && (dev_pct == 100);
            issue_cmd(16'($urandom), 16'($urandom_range(0, 24)));
            wait_done(full);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
